// File: rtl/nibble_deshifter.sv
// Collects DEPTH 4-bit nibbles from si into a 4*DEPTH-bit word on po, pulsing pv on completion.
// Build option: define NIBBLE_DESHIFTER_MSB_FIRST_EN to place the first nibble in the top of po.
module nibble_deshifter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           si,
  input  logic                 shn,
  input  logic                 clr,
  output logic [4*DEPTH-1:0]   po,
  output logic                 pv,
  output logic [CW-1:0]        cnt,
  output logic                 busy
);

  localparam int unsigned W = 4 * DEPTH;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_shifted;
  logic [CW-1:0] cnt_inc;

`ifdef NIBBLE_DESHIFTER_MSB_FIRST_EN
  always_comb begin
    sr_shifted = {sr[W-5:0], si};
  end
`else
  always_comb begin
    sr_shifted = {si, sr[W-1:4]};
  end
`endif

  // Leaving IDLE always starts the count at one, whatever cnt held.
  always_comb begin
    cnt_inc = (state == IDLE) ? CW'(1) : cnt + CW'(1);
  end

  assign busy = (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      po    <= '0;
      pv    <= 1'b0;
    end else begin
      pv <= 1'b0;
      if (clr) begin
        state <= IDLE;
        sr    <= '0;
        cnt   <= '0;
      end else if (shn) begin
        if (cnt == LAST) begin
          po    <= sr_shifted;
          pv    <= 1'b1;
          state <= IDLE;
          sr    <= '0;
          cnt   <= '0;
        end else begin
          state <= COLLECT;
          sr    <= sr_shifted;
          cnt   <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_deshifter.sv
// Scoreboard bench for nibble_deshifter (DEPTH=4): directed scenarios plus random stream.
module tb_nibble_deshifter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        si  = '0;
  logic              shn = 1'b0;
  logic              clr = 1'b0;
  logic [4*DEPTH-1:0] po;
  logic              pv;
  logic [CW-1:0]     cnt;
  logic              busy;

  nibble_deshifter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .si(si), .shn(shn), .clr(clr),
    .po(po), .pv(pv), .cnt(cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] expq[$];
  logic [3:0]  part[$];
  logic [15:0] m_po  = '0;
  logic        m_pv  = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack_word();
    logic [15:0] w = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef NIBBLE_DESHIFTER_MSB_FIRST_EN
      w = w | (16'(part[i]) << (4 * (int'(DEPTH) - 1 - i)));
`else
      w = w | (16'(part[i]) << (4 * i));
`endif
    end
    return w;
  endfunction

  function automatic logic [15:0] word_of(input logic [3:0] a, b, c, d);
`ifdef NIBBLE_DESHIFTER_MSB_FIRST_EN
    return {a, b, c, d};
`else
    return {d, c, b, a};
`endif
  endfunction

  task automatic step(input logic [3:0] d, input logic s, input logic c);
    logic [15:0] w;
    si = d; shn = s; clr = c;
    @(posedge clk);
    m_pv = 1'b0;
    if (c) begin
      part.delete();
    end else if (s) begin
      part.push_back(d);
      if (part.size() == DEPTH) begin
        w = pack_word();
        m_po = w;
        m_pv = 1'b1;
        expq.push_back(w);
        part.delete();
      end
    end
    m_cnt = part.size();
    @(negedge clk);
  endtask

  // Monitor: compares registered outputs to the model, pops the scoreboard on every pv.
  always @(negedge clk) begin
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("pv", 32'(pv), 32'(m_pv));
    chk("po_hold", 32'(po), 32'(m_po));
    if (pv === 1'b1) begin
      if (expq.size() == 0) chk("sb_unexpected_pv", 32'(1), 32'(0));
      else chk("sb_po", 32'(po), 32'(expq.pop_front()));
    end
  end

  logic [15:0] saved_po;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_po", 32'(po), 32'(0));
    chk("reset_cnt", 32'(cnt), 32'(0));
    rst = 1'b1;

    // Idle with shn low: nothing may complete.
    for (int i = 0; i < 20; i++) begin
      step(4'($urandom), 1'b0, 1'b0);
      chk("idle_pv", 32'(pv), 32'(0));
      chk("idle_po", 32'(po), 32'(0));
    end

    // Basic word A,5,C,3
    step(4'hA, 1'b1, 1'b0); chk("seq_cnt1", 32'(cnt), 32'(1));
    step(4'h5, 1'b1, 1'b0); chk("seq_cnt2", 32'(cnt), 32'(2));
    step(4'hC, 1'b1, 1'b0); chk("seq_cnt3", 32'(cnt), 32'(3));
    chk("seq_pv_early", 32'(pv), 32'(0));
    step(4'h3, 1'b1, 1'b0); chk("seq_cnt0", 32'(cnt), 32'(0));
    chk("seq_pv", 32'(pv), 32'(1));
    chk("seq_po", 32'(po), 32'(word_of(4'hA, 4'h5, 4'hC, 4'h3)));
    step(4'h0, 1'b0, 1'b0);
    chk("seq_pv_drop", 32'(pv), 32'(0));

    // Same word with a 5-cycle gap after 2 nibbles
    step(4'hA, 1'b1, 1'b0);
    step(4'h5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'($urandom), 1'b0, 1'b0);
      chk("gap_cnt", 32'(cnt), 32'(2));
      chk("gap_busy", 32'(busy), 32'(1));
    end
    step(4'hC, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    chk("gap_pv", 32'(pv), 32'(1));
    chk("gap_po", 32'(po), 32'(word_of(4'hA, 4'h5, 4'hC, 4'h3)));

    // Back-to-back 1..8
    for (int i = 1; i <= 8; i++) begin
      step(4'(i), 1'b1, 1'b0);
      chk("b2b_pv", 32'(pv), 32'((i % 4) == 0));
      if (i == 4) chk("b2b_po1", 32'(po), 32'(word_of(4'h1, 4'h2, 4'h3, 4'h4)));
      if (i == 8) chk("b2b_po2", 32'(po), 32'(word_of(4'h5, 4'h6, 4'h7, 4'h8)));
    end

    // Clear together with shn after 3 nibbles
    saved_po = po;
    step(4'h9, 1'b1, 1'b0);
    step(4'hB, 1'b1, 1'b0);
    step(4'hD, 1'b1, 1'b0);
    step(4'hE, 1'b1, 1'b1);
    chk("clr_cnt", 32'(cnt), 32'(0));
    chk("clr_pv", 32'(pv), 32'(0));
    chk("clr_po", 32'(po), 32'(saved_po));
    step(4'h1, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0);
    step(4'h4, 1'b1, 1'b0);
    chk("clr_next_po", 32'(po), 32'(word_of(4'h1, 4'h2, 4'h3, 4'h4)));

    // Asynchronous reset mid-word
    step(4'h7, 1'b1, 1'b0);
    step(4'h6, 1'b1, 1'b0);
    shn = 1'b0;
    #2 rst = 1'b0;
    part.delete(); m_po = '0; m_pv = 1'b0; m_cnt = 0;
    #1;
    chk("arst_po", 32'(po), 32'(0));
    chk("arst_pv", 32'(pv), 32'(0));
    chk("arst_cnt", 32'(cnt), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    step(4'hF, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    step(4'hE, 1'b1, 1'b0);
    step(4'h1, 1'b1, 1'b0);
    chk("arst_word", 32'(po), 32'(word_of(4'hF, 4'h0, 4'hE, 4'h1)));

    // Random stream
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    step(4'h0, 1'b0, 1'b0);
    chk("sb_drained", 32'(expq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_deshifter.md
# nibble_deshifter

Serial-to-parallel collector for the 4-bit nibble stream produced by the lane shifter. Each enabled clock edge accepts one nibble on `si`. After `DEPTH` accepted nibbles it presents the assembled word on `po` and pulses `pv` for one cycle. It sits at the receiving end of the shifter path, rebuilding the words the shifter serialises.

## Interface
- `DEPTH`, 4: nibbles per word; legal range 2..8.
- `CW`, 3: width of `cnt`; must satisfy 2^CW > DEPTH.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `si` input 4: nibble data; sampled only when `shn`=1.
- `shn` input 1: shift enable; 1 accepts `si` this edge, 0 holds state.
- `clr` input 1: synchronous abort of the partial word.
- `po` output 4*DEPTH: last completed word; holds until the next completion.
- `pv` output 1: one-cycle pulse; `po` updated on this edge.
- `cnt` output CW: nibbles accepted in the current partial word, 0..DEPTH-1.
- `busy` output 1: high while 0 < `cnt` (partial word in progress).

## Operation
- Internal shift register `sr` is 4*DEPTH bits wide. Counter `cnt` is a 2-state FSM.
  - IDLE: `cnt`=0.
  - COLLECT: 0 < `cnt` < DEPTH.
- Edge with `shn`=1, `clr`=0:
  - `si` is shifted into `sr` (direction set by Configuration).
  - `cnt` increments.
  - IDLE moves to COLLECT.
- Edge where the accepted nibble is the DEPTH-th:
  - `po` <= `sr` including that nibble.
  - `pv` <= 1.
  - `cnt` <= 0; `sr` <= 0; FSM returns to IDLE.
  - The next word can start on the following edge with no bubble.
- Edge with `shn`=0, `clr`=0:
  - `sr` and `cnt` hold, so a partial word pauses indefinitely.
  - `pv` <= 0.
- `clr`=1 (wins over `shn`):
  - `cnt` <= 0, `sr` <= 0, FSM to IDLE, `pv` <= 0.
  - The nibble on `si` that edge is discarded.
  - `po` is not changed.
- `pv` is 0 on every edge that does not complete a word. Back-to-back words give `pv` pulses exactly DEPTH cycles apart.
- `busy` is combinational from `cnt` (`cnt` != 0).
- `rst`=0 at any time, including mid-word: immediately `sr`=0, `cnt`=0, `po`=0, `pv`=0, `busy`=0, FSM=IDLE. The partial word is lost.
- After `rst` rises, the first nibble is accepted on the first rising edge with `shn`=1.

## Timing
- Capture latency: a nibble is registered on the edge where `shn`=1.
- Word latency: `po`/`pv` are valid immediately after the edge that accepts the last nibble (0 extra cycles).
- `po` is stable from that edge until the next completion edge, clear or not.
- No combinational path from `si` or `shn` to any output except through registers. `busy` depends only on registers.
- Reset values: `po`=0, `pv`=0, `cnt`=0, `busy`=0.

## Configuration
- Macro: `NIBBLE_DESHIFTER_MSB_FIRST_EN`.
- Defined: the first accepted nibble lands in `po[4*DEPTH-1 -: 4]`. `sr` shifts left, and the new nibble enters bits [3:0].
- Undefined: the first accepted nibble lands in `po[3:0]`. `sr` shifts right, and the new nibble enters the top 4 bits.
- All handshake, count and timing behaviour is identical in both builds.

## Test plan
All scenarios use DEPTH=4.
- Reset, then `si`=A,5,C,3 with `shn`=1 on 4 consecutive edges:
  - MSB build: `po`=16'hA5C3.
  - LSB build: `po`=16'h3C5A.
  - Both builds: `pv` high exactly one cycle after the 4th edge; `cnt` sequence 1,2,3,0.
- Same stream with `shn`=0 for 5 cycles after the 2nd nibble:
  - `cnt` holds 2 and `busy`=1 during the gap.
  - Final `po` is identical to the uninterrupted case.
  - `pv` pulses once.
- Two words back-to-back (8 consecutive nibbles 1..8):
  - `pv` pulses 4 cycles apart.
  - MSB build: `po`=16'h1234, then 16'h5678.
- `clr`=1 together with `shn`=1 after 3 nibbles:
  - `cnt`=0, no `pv`, `po` keeps its previous value.
  - The next 4 nibbles form a clean word.
- `rst` driven low between clock edges after 2 nibbles:
  - All outputs are 0 before the next edge.
  - After release, 4 nibbles produce a correct word.
- `shn`=0 for 20 cycles from reset: `pv` never asserts, `po` stays 0.
